// File: rtl/nonrestoring_divider.sv
// Signed non-restoring divider, one quotient bit per cycle; done WIDTH+2 cycles after accept (2 if divisor==0).
// No backpressure: start is taken only in IDLE and ignored while busy; results hold until the next done.
module nonrestoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   pr_q, pr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dm_q, dm_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   pr_sh, pr_step, pr_fix;

    // Partial remainder is WIDTH+1 bits so that |divisor| = 2^(WIDTH-1) cannot overflow.
    assign pr_sh   = {pr_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign pr_step = pr_q[WIDTH] ? (pr_sh + {1'b0, dm_q}) : (pr_sh - {1'b0, dm_q});
    assign pr_fix  = pr_q[WIDTH] ? (pr_q + {1'b0, dm_q}) : pr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        q_d     = q_q;
        dm_d    = dm_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    negq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    negr_d = dividend[WIDTH-1];
                    dm_d   = divisor[WIDTH-1] ? (-divisor) : divisor;
                    cnt_d  = '0;
                    if (divisor == '0) begin
                        // Zero divisor skips the iterations; FIX leaves these results untouched.
                        dz_d    = 1'b1;
                        q_d     = '1;
                        pr_d    = {dividend[WIDTH-1], dividend};
                        state_d = FIX;
                    end else begin
                        dz_d    = 1'b0;
                        q_d     = dividend[WIDTH-1] ? (-dividend) : dividend;
                        pr_d    = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                pr_d  = pr_step;
                q_d   = {q_q[WIDTH-2:0], ~pr_step[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (!dz_q) begin
                    q_d  = negq_q ? (-q_q) : q_q;
                    pr_d = negr_q ? (-pr_fix) : pr_fix;
                end
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                quot_d  = q_q;
                rem_d   = pr_q[WIDTH-1:0];
                dbz_d   = dz_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            q_q     <= '0;
            dm_q    <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            q_q     <= q_d;
            dm_q    <= dm_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_nonrestoring_divider.sv
// Randomized and directed bench for nonrestoring_divider against a 64-bit arithmetic reference model.
module tb_nonrestoring_divider;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    int checks = 0;
    int failures = 0;

    nonrestoring_divider #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: truncating signed division on 64-bit values, results cut to 32 bits.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint la, lb, lq, lr;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
        end else begin
            lq = la / lb;
            lr = la % lb;
            q = lq[31:0]; r = lr[31:0]; dz = 1'b0;
        end
    endtask

    // Call #1 after a rising edge; returns #1 after the done edge.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit inject, input string tag);
        logic [31:0] eq, er, q0, r0;
        logic        edz;
        int          lat, n;
        bit          seen, stable, busy_ok;
        model(a, b, eq, er, edz);
        lat = (b == 32'd0) ? 2 : 34;
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        q0 = quotient; r0 = remainder;
        stable = 1'b1; busy_ok = 1'b1; seen = 1'b0; n = 0;
        while (!seen && n < 100) begin
            @(posedge clk); n++; #1;
            if (inject && n == 9) begin dividend = ~a; divisor = b + 32'd3; start = 1'b1; end
            if (inject && n == 10) start = 1'b0;
            if (done) seen = 1'b1;
            else begin
                if (quotient !== q0 || remainder !== r0) stable = 1'b0;
                if (busy !== 1'b1) busy_ok = 1'b0;
            end
        end
        chk({tag, ":latency"}, 64'(n), 64'(lat));
        chk({tag, ":quotient"}, {32'd0, quotient}, {32'd0, eq});
        chk({tag, ":remainder"}, {32'd0, remainder}, {32'd0, er});
        chk({tag, ":div_by_zero"}, {63'd0, div_by_zero}, {63'd0, edz});
        chk({tag, ":stable"}, {63'd0, stable}, 64'd1);
        chk({tag, ":busy"}, {63'd0, busy_ok}, 64'd1);
        chk({tag, ":busy_after"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ":busy"}, {63'd0, busy}, 64'd0);
        chk({tag, ":done"}, {63'd0, done}, 64'd0);
        chk({tag, ":quotient"}, {32'd0, quotient}, 64'd0);
        chk({tag, ":remainder"}, {32'd0, remainder}, 64'd0);
        chk({tag, ":div_by_zero"}, {63'd0, div_by_zero}, 64'd0);
    endtask

    initial begin
        int  dones;
        logic [31:0] a, b;
        #1 reset_n = 1'b0;
        #1 chk_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        do_div(32'd100, 32'd7, 1'b0, "p100_p7");
        do_div(-32'sd100, 32'd7, 1'b0, "n100_p7");
        do_div(32'd100, -32'sd7, 1'b0, "p100_n7");
        do_div(32'd5, 32'd0, 1'b0, "div0");
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "min_n1");
        do_div(32'h7FFF_FFFF, 32'd1, 1'b0, "max_p1");
        do_div(32'd100, 32'd7, 1'b1, "ignore_start");
        do_div(32'd1000, 32'd33, 1'b0, "back_to_back");
        @(posedge clk); #1;
        chk("done_single_pulse", {63'd0, done}, 64'd0);

        // Reset in the middle of an operation.
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1 reset_n = 1'b0;
        #1 chk_zero("mid_reset");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("mid_reset:no_done", 64'(dones), 64'd0);
        do_div(32'd9, 32'd3, 1'b0, "after_reset");

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                3:       b = 32'hFFFF_FFFF;
                4:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            do_div(a, b, 1'b0, $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
